// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART transmit framer:
// parity-mode encodings, FSM state encoding and the parity-bit helper.
package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;
    localparam logic [1:0] PAR_MARK = 2'b11;

    // Each state is named after the bit currently on the line.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARM    = 3'd1,
        START  = 3'd2,
        DATA   = 3'd3,
        PARITY = 3'd4,
        STOP   = 3'd5
    } tx_state_e;

    // even_par is the XOR of the latched data word.
    function automatic logic parity_bit(input logic [1:0] mode, input logic even_par);
        case (mode)
            PAR_EVEN: parity_bit = even_par;
            PAR_ODD:  parity_bit = ~even_par;
            PAR_MARK: parity_bit = 1'b1;
            default:  parity_bit = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/uart_tx_shreg.sv
// Data shift register for the UART framer: loads a word, shifts one bit per
// request in the configured order and keeps the word's even parity.
module uart_tx_shreg #(
    parameter int DATA_BITS = 8,
    parameter int MSB_FIRST = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic                 shift,
    input  logic [DATA_BITS-1:0] din,
    output logic                 bit_out,
    output logic                 par_out
);

    logic [DATA_BITS-1:0] sh_q, sh_d, sh_next_s;
    logic                 par_q, par_d;

    // The outgoing bit always sits at the end selected by MSB_FIRST.
    generate
        if (MSB_FIRST != 0) begin : g_msb
            assign bit_out   = sh_q[DATA_BITS-1];
            assign sh_next_s = {sh_q[DATA_BITS-2:0], 1'b0};
        end else begin : g_lsb
            assign bit_out   = sh_q[0];
            assign sh_next_s = {1'b0, sh_q[DATA_BITS-1:1]};
        end
    endgenerate

    assign par_out = par_q;

    // Next-state: load has priority over shift; parity is fixed at load time.
    always_comb begin
        sh_d  = sh_q;
        par_d = par_q;
        if (load) begin
            sh_d  = din;
            par_d = ^din;
        end else if (shift) begin
            sh_d = sh_next_s;
        end else begin
            sh_d = sh_q;
        end
    end

    // Shift register and parity flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q  <= '0;
            par_q <= 1'b0;
        end else begin
            sh_q  <= sh_d;
            par_q <= par_d;
        end
    end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmit framer: pops words from a FWFT FIFO and sends start, data,
// optional parity and stop bits paced by an external baud tick.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1,
    parameter int MSB_FIRST = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tx_clk_bps,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_buf_not_empty,
    output logic                 tx_read_buf,
    input  logic [1:0]           parity_mode,
    output logic                 tx_pin_out,
    output logic                 tx_band_sig,
    output logic                 tx_done
);

    localparam int                CNT_W     = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(DATA_BITS - 1);
    localparam logic              STOP_LAST = 1'(STOP_BITS - 1);

    tx_state_e        state_q, state_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             stop_cnt_q, stop_cnt_d;
    logic [1:0]       mode_q, mode_d;
    logic             pin_q, pin_d;
    logic             band_q, band_d;
    logic             read_q, read_d;
    logic             done_q, done_d;
    logic             load_s, shift_s, sh_bit_s, sh_par_s;

    uart_tx_shreg #(
        .DATA_BITS(DATA_BITS),
        .MSB_FIRST(MSB_FIRST)
    ) u_shreg (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (load_s),
        .shift  (shift_s),
        .din    (tx_data),
        .bit_out(sh_bit_s),
        .par_out(sh_par_s)
    );

    // Framing FSM next-state; every output is registered so the line only moves on ticks.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        mode_d     = mode_q;
        pin_d      = pin_q;
        band_d     = band_q;
        read_d     = 1'b0;
        done_d     = 1'b0;
        load_s     = 1'b0;
        shift_s    = 1'b0;
        case (state_q)
            IDLE: begin
                pin_d = 1'b1;
                if (tx_buf_not_empty) begin
                    read_d  = 1'b1;
                    load_s  = 1'b1;
                    mode_d  = parity_mode;
                    band_d  = 1'b1;
                    state_d = ARM;
                end else begin
                    band_d = 1'b0;
                end
            end
            ARM: begin
                if (tx_clk_bps) begin
                    pin_d   = 1'b0;
                    state_d = START;
                end else begin
                    state_d = ARM;
                end
            end
            START: begin
                if (tx_clk_bps) begin
                    pin_d     = sh_bit_s;
                    shift_s   = 1'b1;
                    bit_cnt_d = '0;
                    state_d   = DATA;
                end else begin
                    state_d = START;
                end
            end
            DATA: begin
                if (tx_clk_bps) begin
                    if (bit_cnt_q != LAST_BIT) begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        pin_d     = sh_bit_s;
                        shift_s   = 1'b1;
                    end else if (mode_q != PAR_NONE) begin
                        pin_d   = parity_bit(mode_q, sh_par_s);
                        state_d = PARITY;
                    end else begin
                        pin_d      = 1'b1;
                        stop_cnt_d = 1'b0;
                        state_d    = STOP;
                    end
                end else begin
                    state_d = DATA;
                end
            end
            PARITY: begin
                if (tx_clk_bps) begin
                    pin_d      = 1'b1;
                    stop_cnt_d = 1'b0;
                    state_d    = STOP;
                end else begin
                    state_d = PARITY;
                end
            end
            STOP: begin
                if (tx_clk_bps) begin
                    if (stop_cnt_q != STOP_LAST) begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end else begin
                        done_d = 1'b1;
                        // Back-to-back: the next start bit begins on this same tick.
                        if (tx_buf_not_empty) begin
                            read_d  = 1'b1;
                            load_s  = 1'b1;
                            mode_d  = parity_mode;
                            pin_d   = 1'b0;
                            state_d = START;
                        end else begin
                            pin_d   = 1'b1;
                            band_d  = 1'b0;
                            state_d = IDLE;
                        end
                    end
                end else begin
                    state_d = STOP;
                end
            end
            default: begin
                state_d = IDLE;
                pin_d   = 1'b1;
                band_d  = 1'b0;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            mode_q     <= PAR_NONE;
            pin_q      <= 1'b1;
            band_q     <= 1'b0;
            read_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            mode_q     <= mode_d;
            pin_q      <= pin_d;
            band_q     <= band_d;
            read_q     <= read_d;
            done_q     <= done_d;
        end
    end

    assign tx_pin_out  = pin_q;
    assign tx_band_sig = band_q;
    assign tx_read_buf = read_q;
    assign tx_done     = done_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Self-checking bench for uart_tx_frame: three parameterisations driven from
// FIFO models, line bits compared against a frame-level reference model.
`timescale 1ns/1ps
module tb_uart_tx_frame;

    localparam int ND = 3;

    logic clk = 1'b0;
    logic rst_n;

    logic       tick_s [ND] = '{default: 1'b0};
    logic       ne_s   [ND] = '{default: 1'b0};
    logic [8:0] data_s [ND] = '{default: 9'd0};
    logic [1:0] mode_s [ND] = '{default: 2'd0};
    logic       rd_s   [ND];
    logic       pin_s  [ND];
    logic       band_s [ND];
    logic       done_s [ND];

    int          period   [ND];
    int          tcnt     [ND];
    logic [10:0] fifo_mem [ND][16];
    int          f_rd     [ND];
    int          f_wr     [ND];
    bit          cap      [ND];
    bit          rec_mem  [ND][1024];
    int          rec_n    [ND];
    int          done_cnt [ND];
    int          rd_cnt   [ND];
    int          viol     [ND];
    int          uflow    [ND];
    logic        band_prev[ND] = '{default: 1'b0};
    logic        pin_prev [ND] = '{default: 1'b1};

    logic [10:0]  pend[$];
    logic [255:0] exp_bits, obs_bits;
    int           exp_len, obs_len, obs_done, obs_rd, obs_low, obs_viol;
    bit           obs_to;
    int           ncmp, nfail;

    always #5 clk = ~clk;

    uart_tx_frame #(.DATA_BITS(8), .STOP_BITS(1), .MSB_FIRST(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .tx_clk_bps(tick_s[0]), .tx_data(data_s[0][7:0]),
        .tx_buf_not_empty(ne_s[0]), .tx_read_buf(rd_s[0]), .parity_mode(mode_s[0]),
        .tx_pin_out(pin_s[0]), .tx_band_sig(band_s[0]), .tx_done(done_s[0]));

    uart_tx_frame #(.DATA_BITS(7), .STOP_BITS(1), .MSB_FIRST(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .tx_clk_bps(tick_s[1]), .tx_data(data_s[1][6:0]),
        .tx_buf_not_empty(ne_s[1]), .tx_read_buf(rd_s[1]), .parity_mode(mode_s[1]),
        .tx_pin_out(pin_s[1]), .tx_band_sig(band_s[1]), .tx_done(done_s[1]));

    uart_tx_frame #(.DATA_BITS(8), .STOP_BITS(2), .MSB_FIRST(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .tx_clk_bps(tick_s[2]), .tx_data(data_s[2][7:0]),
        .tx_buf_not_empty(ne_s[2]), .tx_read_buf(rd_s[2]), .parity_mode(mode_s[2]),
        .tx_pin_out(pin_s[2]), .tx_band_sig(band_s[2]), .tx_done(done_s[2]));

    function automatic int db_of(input int d);  return (d == 1) ? 7 : 8; endfunction
    function automatic int sb_of(input int d);  return (d == 2) ? 2 : 1; endfunction
    function automatic int msb_of(input int d); return (d == 2) ? 1 : 0; endfunction

    // Line monitor, tick generator and FIFO model, all on the falling edge.
    always @(negedge clk) begin
        for (int d = 0; d < ND; d++) begin
            if (cap[d] && tick_s[d] && band_prev[d]) begin
                rec_mem[d][rec_n[d] % 1024] = pin_s[d];
                rec_n[d] = rec_n[d] + 1;
            end
            if (rst_n && (pin_s[d] !== pin_prev[d]) && !tick_s[d]) viol[d] = viol[d] + 1;
            if (done_s[d]) done_cnt[d] = done_cnt[d] + 1;
            if (rd_s[d]) begin
                rd_cnt[d] = rd_cnt[d] + 1;
                if (f_rd[d] == f_wr[d]) uflow[d] = uflow[d] + 1;
                else f_rd[d] = f_rd[d] + 1;
            end
            band_prev[d] = band_s[d];
            pin_prev[d]  = pin_s[d];
            if (period[d] == 0) begin
                tick_s[d] = 1'b0;
            end else begin
                tcnt[d]   = (tcnt[d] + 1) % period[d];
                tick_s[d] = (tcnt[d] == 0);
            end
            if (f_rd[d] != f_wr[d]) begin
                data_s[d] = fifo_mem[d][f_rd[d] % 16][8:0];
                mode_s[d] = fifo_mem[d][f_rd[d] % 16][10:9];
                ne_s[d]   = 1'b1;
            end else begin
                data_s[d] = 9'($urandom);
                mode_s[d] = 2'($urandom);
                ne_s[d]   = 1'b0;
            end
        end
    end

    // Reference: per frame start 0, data bits in order, optional parity, stop 1s; idle 1 after the last frame.
    task automatic model_frames(input int d);
        int          db, sb;
        logic [8:0]  w;
        logic [1:0]  m;
        logic        p;
        int          ones;
        db = db_of(d);
        sb = sb_of(d);
        exp_bits = '0;
        exp_len  = 0;
        foreach (pend[i]) begin
            w = pend[i][8:0];
            m = pend[i][10:9];
            exp_bits[exp_len] = 1'b0; exp_len++;
            ones = 0;
            for (int b = 0; b < db; b++) begin
                exp_bits[exp_len] = (msb_of(d) != 0) ? w[db-1-b] : w[b];
                if (w[b]) ones++;
                exp_len++;
            end
            if (m != 2'b00) begin
                if (m == 2'b01) p = (ones % 2) == 1;
                else if (m == 2'b10) p = (ones % 2) == 0;
                else p = 1'b1;
                exp_bits[exp_len] = p; exp_len++;
            end
            for (int s = 0; s < sb; s++) begin
                exp_bits[exp_len] = 1'b1; exp_len++;
            end
        end
        exp_bits[exp_len] = 1'b1; exp_len++;
    endtask

    // Preloads pend into a FIFO, runs until all frames complete and gathers observations.
    task automatic send_frames(input int d, input int per);
        int base, d0, r0, v0, n, cyc, budget;
        @(negedge clk); #1;
        period[d] = per;
        cap[d]    = 1'b1;
        base = rec_n[d]; d0 = done_cnt[d]; r0 = rd_cnt[d]; v0 = viol[d];
        n = pend.size();
        foreach (pend[i]) begin
            fifo_mem[d][f_wr[d] % 16] = pend[i];
            f_wr[d] = f_wr[d] + 1;
        end
        model_frames(d);
        budget = (n * 14 + 6) * per + 20;
        cyc = 0;
        obs_low = 0;
        while ((done_cnt[d] - d0) < n && cyc < budget) begin
            @(negedge clk); #1;
            cyc++;
            if (rd_cnt[d] != r0 && (done_cnt[d] - d0) < n && band_s[d] !== 1'b1) obs_low++;
        end
        obs_to = (cyc >= budget);
        repeat (2 * per + 2) @(negedge clk);
        #1;
        cap[d]   = 1'b0;
        obs_len  = rec_n[d] - base;
        obs_bits = '0;
        for (int i = 0; i < obs_len && i < 256; i++) obs_bits[i] = rec_mem[d][(base + i) % 1024];
        obs_done = done_cnt[d] - d0;
        obs_rd   = rd_cnt[d] - r0;
        obs_viol = viol[d] - v0;
        pend.delete();
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        #1;
        for (int d = 0; d < ND; d++) begin
            ncmp++; if (pin_s[d] !== 1'b1) begin nfail++; $display("FAIL reset_pin[%0d]: got %b want 1", d, pin_s[d]); end
            ncmp++; if (band_s[d] !== 1'b0) begin nfail++; $display("FAIL reset_band[%0d]: got %b want 0", d, band_s[d]); end
            ncmp++; if (rd_s[d] !== 1'b0) begin nfail++; $display("FAIL reset_read[%0d]: got %b want 0", d, rd_s[d]); end
            ncmp++; if (done_s[d] !== 1'b0) begin nfail++; $display("FAIL reset_done[%0d]: got %b want 0", d, done_s[d]); end
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_8n1;
        pend.push_back({2'b00, 9'h055});
        send_frames(0, 16);
        ncmp++; if (obs_to || obs_len != 11 || obs_bits[10:0] !== 11'b110_1010_1010) begin
            nfail++; $display("FAIL 8n1_line: got len %0d bits %b timeout %0d want len 11 bits 11010101010", obs_len, obs_bits[10:0], obs_to); end
        ncmp++; if (obs_len != exp_len || obs_bits !== exp_bits) begin
            nfail++; $display("FAIL 8n1_model: got len %0d %h want len %0d %h", obs_len, obs_bits, exp_len, exp_bits); end
        ncmp++; if (obs_done != 1 || obs_rd != 1) begin nfail++; $display("FAIL 8n1_pulses: got done %0d read %0d want 1 1", obs_done, obs_rd); end
        ncmp++; if (band_s[0] !== 1'b0 || obs_viol != 0) begin nfail++; $display("FAIL 8n1_band_idle: got band %b offtick %0d want 0 0", band_s[0], obs_viol); end
    endtask

    task automatic test_parity;
        for (int k = 0; k < 2; k++) begin
            pend.push_back({(k == 0) ? 2'b01 : 2'b10, 9'h043});
            send_frames(1, 8);
            ncmp++; if (obs_to || obs_len != exp_len || obs_bits !== exp_bits) begin
                nfail++; $display("FAIL parity%0d_line: got len %0d %h want len %0d %h", k, obs_len, obs_bits, exp_len, exp_bits); end
            ncmp++; if (obs_bits[8] !== ((k == 0) ? 1'b1 : 1'b0) || obs_bits[9] !== 1'b1) begin
                nfail++; $display("FAIL parity%0d_bit: got par %b stop %b want %b 1", k, obs_bits[8], obs_bits[9], (k == 0)); end
        end
    endtask

    task automatic test_back_to_back;
        pend.push_back({2'b00, 9'h0A1});
        pend.push_back({2'b00, 9'h0B2});
        pend.push_back({2'b00, 9'h0C3});
        send_frames(2, 6);
        ncmp++; if (obs_to || obs_len != 34 || obs_len != exp_len || obs_bits !== exp_bits) begin
            nfail++; $display("FAIL b2b_line: got len %0d %h want len %0d %h", obs_len, obs_bits, exp_len, exp_bits); end
        ncmp++; if (obs_done != 3 || obs_rd != 3) begin nfail++; $display("FAIL b2b_pulses: got done %0d read %0d want 3 3", obs_done, obs_rd); end
        ncmp++; if (obs_low != 0) begin nfail++; $display("FAIL b2b_band_gap: got %0d low cycles want 0", obs_low); end
    endtask

    task automatic test_msb_first;
        logic [7:0] first8;
        pend.push_back({2'b00, 9'h080});
        send_frames(2, 3);
        first8 = obs_bits[8:1];
        ncmp++; if (obs_to || first8 !== 8'h01 || obs_bits[0] !== 1'b0) begin
            nfail++; $display("FAIL msb_first: got start %b data(first at lsb) %b want 0 00000001", obs_bits[0], first8); end
        ncmp++; if (obs_len != exp_len || obs_bits !== exp_bits) begin
            nfail++; $display("FAIL msb_model: got len %0d %h want len %0d %h", obs_len, obs_bits, exp_len, exp_bits); end
    endtask

    task automatic test_tick_pop;
        int r0, d0, k, guard;
        @(negedge clk); #1;
        period[0] = 4;
        guard = 0;
        while (tcnt[0] != 3 && guard < 20) begin @(negedge clk); #1; guard++; end
        r0 = rd_cnt[0]; d0 = done_cnt[0];
        fifo_mem[0][f_wr[0] % 16] = {2'b00, 9'h03C};
        f_wr[0] = f_wr[0] + 1;
        @(negedge clk); #1;
        ncmp++; if (tick_s[0] !== 1'b1 || ne_s[0] !== 1'b1) begin
            nfail++; $display("FAIL tickpop_setup: got tick %b nonempty %b want 1 1", tick_s[0], ne_s[0]); end
        @(posedge clk); #1;
        ncmp++; if (rd_s[0] !== 1'b1 || band_s[0] !== 1'b1 || pin_s[0] !== 1'b1) begin
            nfail++; $display("FAIL tickpop_pop: got read %b band %b pin %b want 1 1 1", rd_s[0], band_s[0], pin_s[0]); end
        k = 0;
        while (k < 12) begin
            @(posedge clk); #1;
            k++;
            if (pin_s[0] === 1'b0) break;
        end
        ncmp++; if (k != 4) begin nfail++; $display("FAIL tickpop_start_delay: got %0d clk want 4", k); end
        guard = 0;
        while (done_cnt[0] == d0 && guard < 200) begin @(negedge clk); guard++; end
        ncmp++; if (done_cnt[0] - d0 != 1 || rd_cnt[0] - r0 != 1) begin
            nfail++; $display("FAIL tickpop_finish: got done %0d read %0d want 1 1", done_cnt[0] - d0, rd_cnt[0] - r0); end
    endtask

    task automatic test_random;
        int per;
        for (int d = 0; d < ND; d++) begin
            for (int r = 0; r < 2; r++) begin
                per = $urandom_range(1, 5);
                for (int i = 0; i < 3; i++) pend.push_back(11'($urandom));
                send_frames(d, per);
                ncmp++; if (obs_to || obs_len != exp_len || obs_bits !== exp_bits) begin
                    nfail++; $display("FAIL rand_line[%0d.%0d] per %0d: got len %0d %h want len %0d %h", d, r, per, obs_len, obs_bits, exp_len, exp_bits); end
                ncmp++; if (obs_done != 3 || obs_rd != 3 || obs_low != 0 || obs_viol != 0) begin
                    nfail++; $display("FAIL rand_ctl[%0d.%0d]: got done %0d read %0d gap %0d offtick %0d want 3 3 0 0", d, r, obs_done, obs_rd, obs_low, obs_viol); end
            end
        end
    endtask

    task automatic test_reset_midframe;
        int base, d0, r0, guard, busy;
        @(negedge clk); #1;
        period[0] = 4;
        cap[0] = 1'b1;
        base = rec_n[0]; d0 = done_cnt[0]; r0 = rd_cnt[0];
        fifo_mem[0][f_wr[0] % 16] = {2'b00, 9'h000};
        f_wr[0] = f_wr[0] + 1;
        guard = 0;
        while (rec_n[0] - base < 4 && guard < 200) begin @(negedge clk); #1; guard++; end
        ncmp++; if (guard >= 200 || pin_s[0] !== 1'b0) begin
            nfail++; $display("FAIL midreset_reach: got pin %b waited %0d want pin 0 before reset", pin_s[0], guard); end
        rst_n = 1'b0;
        #1;
        ncmp++; if (pin_s[0] !== 1'b1 || band_s[0] !== 1'b0) begin
            nfail++; $display("FAIL midreset_async: got pin %b band %b want 1 0", pin_s[0], band_s[0]); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        busy = 0;
        repeat (40) begin
            @(negedge clk); #1;
            if (pin_s[0] !== 1'b1 || band_s[0] !== 1'b0) busy++;
        end
        cap[0] = 1'b0;
        ncmp++; if (busy != 0) begin nfail++; $display("FAIL midreset_idle: got %0d non-idle cycles want 0", busy); end
        ncmp++; if (done_cnt[0] - d0 != 0 || rd_cnt[0] - r0 != 1) begin
            nfail++; $display("FAIL midreset_pulses: got done %0d read %0d want 0 1", done_cnt[0] - d0, rd_cnt[0] - r0); end
    endtask

    initial begin
        rst_n = 1'b0;
        ncmp  = 0;
        nfail = 0;
        test_reset;
        test_8n1;
        test_parity;
        test_back_to_back;
        test_msb_first;
        test_tick_pop;
        test_random;
        test_reset_midframe;
        for (int d = 0; d < ND; d++) begin
            ncmp++; if (uflow[d] != 0 || viol[d] != 0) begin
                nfail++; $display("FAIL hygiene[%0d]: got empty pops %0d offtick changes %0d want 0 0", d, uflow[d], viol[d]); end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Parametrised UART transmit framer that replaces the fixed 8N1 transmitter. It pulls words from a first-word-fall-through TX FIFO and serialises each as start, DATA_BITS data, optional parity and STOP_BITS stop bits, paced by an external baud-tick strobe. Frames can be sent back-to-back with no idle gap, and the block reports per-frame completion. It sits between the TX FIFO and the pad, alongside the existing baud generator.

## Interface
Parameters:
- DATA_BITS, 8: data bits per frame; legal values 5–9.
- STOP_BITS, 1: stop bits per frame; legal values 1–2.
- MSB_FIRST, 0: 0 sends LSB first, 1 sends MSB first.

Ports:
- clk  in  1  system clock; every register is clocked on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- tx_clk_bps  in  1  one-clk baud tick strobe; one bit period spans tick to tick.
- tx_data  in  DATA_BITS  FIFO head word; valid while tx_buf_not_empty is high.
- tx_buf_not_empty  in  1  FIFO holds at least one word.
- tx_read_buf  out  1  one-clk pop strobe; the word is latched in the same cycle.
- parity_mode  in  2  00 none, 01 even, 10 odd, 11 mark (always 1).
- tx_pin_out  out  1  serial line.
- tx_band_sig  out  1  high from pop until the last stop bit completes.
- tx_done  out  1  one-clk pulse when the last stop bit completes.

## Operation
- Reset values: tx_pin_out=1, tx_band_sig=0, tx_read_buf=0, tx_done=0, state=IDLE, all counters 0.
- Each state's name gives the bit currently on the line. All transitions except IDLE→ARM require tx_clk_bps=1.
- IDLE: line high. If tx_buf_not_empty: pulse tx_read_buf, latch tx_data and parity_mode, set tx_band_sig, go to ARM.
- ARM: at tick, tx_pin_out←0, go to START.
- START: at tick, drive the first data bit, bit_cnt←0, go to DATA.
- DATA: at tick:
  - If bit_cnt<DATA_BITS−1: bit_cnt++ and drive the next bit.
  - Else if parity_mode≠00: drive the parity bit, go to PARITY.
  - Else: drive 1, stop_cnt←0, go to STOP.
- PARITY: at tick, drive 1, stop_cnt←0, go to STOP.
- Parity values: even = XOR of the latched data; odd = its inverse; mark = 1.
- STOP: at tick:
  - If stop_cnt<STOP_BITS−1: stop_cnt++ and stay.
  - Otherwise pulse tx_done, then:
    - If tx_buf_not_empty: pulse tx_read_buf, latch the new word and mode, tx_pin_out←0, go to START. tx_band_sig stays high.
    - Else: go to IDLE, tx_band_sig←0.
- Bit order: MSB_FIRST selects data[DATA_BITS−1] down to data[0]; otherwise data[0] upward.
- Changes to tx_data or parity_mode after the latch have no effect on the frame in flight.
- A pop occurs only when tx_buf_not_empty=1. The block never pops an empty FIFO.

## Timing
- Pop to start-bit edge: pop in cycle n, start bit driven at the first tick after cycle n. A tick in cycle n itself is ignored, so the start bit is always a full period.
- Frame length in ticks, start edge to the completing stop tick: 1+DATA_BITS+P+STOP_BITS, where P=1 if parity_mode≠00, else 0.
- Back-to-back: the new start bit begins on the same tick that ends the previous stop bit. tx_done and tx_read_buf pulse in that cycle.
- tx_pin_out is registered and changes only on tick cycles, except for reset.
- Reset mid-frame: the line goes high asynchronously, with no tx_done. The popped word is lost; this is by design.
- tx_clk_bps held high continuously gives one bit per clk; this is legal and used in simulation.

## Structure
- Shared package uart_pkg holds:
  - parity-mode encodings PAR_NONE, PAR_EVEN, PAR_ODD, PAR_MARK;
  - the state encoding IDLE, ARM, START, DATA, PARITY, STOP (3 bits).
- One sub-module, uart_tx_shreg: DATA_BITS shift register with load and shift-on-tick, MSB_FIRST-aware, exposing the current output bit and running parity.
- FSM, counters and handshake live in uart_tx_frame.

## Test plan
- 8N1, LSB first, word 0x55, tick every 16 clk → line 0,1,0,1,0,1,0,1,0,1, each 16 clk; one tx_done; tx_band_sig returns low.
- DATA_BITS=7, parity_mode=01, word 0x43 → 7 data bits then parity 1, stop 1. Repeat with mode 10 → parity 0.
- STOP_BITS=2, FIFO preloaded with 0xA1, 0xB2, 0xC3 → three contiguous frames, no idle gap; three tx_read_buf and three tx_done pulses; tx_band_sig high throughout.
- MSB_FIRST=1, word 0x80 → first data bit 1, then seven 0s.
- tx_buf_not_empty rises in a tick cycle → pop that cycle; start bit begins one full tick period later, not immediately.
- Reset asserted during data bit 3 → tx_pin_out=1 and tx_band_sig=0 within the same cycle, no tx_done. After release with an empty FIFO, the line stays idle.
